// File: rtl/io_flash_programmer.sv
// io_flash_programmer
// IO-bus initiator that loads the 2048x16 IO flash from a byte stream.
// Byte pairs (low byte first) are assembled into 16-bit words and each word
// is issued as one store on the IOOut handshake. Addresses start at StartAddr
// and wrap at the top of the flash.
//
// Optional feature (macro IO_FLASH_PROGRAMMER_VERIFY_EN): after programming,
// every word is read back with a load. The tag and flag of each response are
// checked, and the sum of the read data is compared with WriteChecksum.
//
// Ports:
//   clk, clk_en, sync_rst          clock, global enable, sync active-high reset
//   Start, StartAddr, WordCount    run control (sampled in IDLE only)
//   ByteValid, ByteData, ByteReady byte stream input
//   IOOut_*                        initiator request channel (ACK = valid)
//   IOIn_*                         response channel (REQ = accept)
//   Busy, Done, ChecksumError      status (Done/ChecksumError sticky)
//   WriteChecksum                  mod-2^16 sum of stored words
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | waiting for Start
// COLLECT_LO  | accepting low byte of next word
// COLLECT_HI  | accepting high byte of next word
// WRITE       | store request pending on IOOut
// VERIFY_REQ  | load request pending on IOOut (verify build only)
// VERIFY_RESP | waiting for load response (verify build only)
// DONE        | run finished, returns to IDLE next enabled cycle

module io_flash_programmer #(
  parameter int          ADDR_W        = 11,
  parameter logic [3:0]  RESP_DEST_REG = 4'h1
) (
  input  logic              clk,
  input  logic              clk_en,
  input  logic              sync_rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   WordCount,
  input  logic              ByteValid,
  input  logic [7:0]        ByteData,
  output logic              ByteReady,
  output logic              IOOut_ACK,
  input  logic              IOOut_REQ,
  output logic              IOOut_ResponseRequested,
  output logic [3:0]        IOOut_DestReg,
  output logic [31:0]       IOOut_Data,
  input  logic              IOIn_ACK,
  output logic              IOIn_REQ,
  input  logic              IOIn_RegResponseFlag,
  input  logic              IOIn_MemResponseFlag,
  input  logic [3:0]        IOIn_DestReg,
  input  logic [31:0]       IOIn_Data,
  output logic              Busy,
  output logic              Done,
  output logic              ChecksumError,
  output logic [15:0]       WriteChecksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT_LO, S_COLLECT_HI, S_WRITE,
    S_VERIFY_REQ, S_VERIFY_RESP, S_DONE
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [7:0]        lo_byte;
  logic [15:0]       word;

  logic start_ok, byte_xfer, out_xfer, last_word;

  assign start_ok  = clk_en & Start & (state == S_IDLE);
  assign byte_xfer = clk_en & ByteValid & ByteReady;
  assign out_xfer  = clk_en & IOOut_ACK & IOOut_REQ;
  assign last_word = (remaining == {{ADDR_W{1'b0}}, 1'b1});

`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
  logic [ADDR_W-1:0] start_addr_q;
  logic [ADDR_W:0]   word_count_q;
  logic [15:0]       read_sum, read_sum_nx;
  logic              in_xfer, resp_bad;

  assign in_xfer     = clk_en & IOIn_ACK & IOIn_REQ;
  assign read_sum_nx = read_sum + IOIn_Data[15:0];
  assign resp_bad    = ~IOIn_RegResponseFlag | (IOIn_DestReg != RESP_DEST_REG);

  logic unused_ok;
  assign unused_ok = ^{IOIn_MemResponseFlag, IOIn_Data[31:16]};
`else
  logic unused_ok;
  assign unused_ok = ^{IOIn_ACK, IOIn_RegResponseFlag, IOIn_MemResponseFlag,
                       IOIn_DestReg, IOIn_Data};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (sync_rst)    state <= S_IDLE;
    else if (clk_en) state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:
        if (start_ok)
          next_state = (WordCount == '0) ? S_DONE : S_COLLECT_LO;
      S_COLLECT_LO: if (byte_xfer) next_state = S_COLLECT_HI;
      S_COLLECT_HI: if (byte_xfer) next_state = S_WRITE;
      S_WRITE:
        if (out_xfer) begin
          if (last_word)
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
            next_state = S_VERIFY_REQ;
`else
            next_state = S_DONE;
`endif
          else
            next_state = S_COLLECT_LO;
        end
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      S_VERIFY_REQ:  if (out_xfer) next_state = S_VERIFY_RESP;
      S_VERIFY_RESP:
        if (in_xfer) next_state = last_word ? S_DONE : S_VERIFY_REQ;
`endif
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so requests stay stable while stalled.
  always_comb begin
    ByteReady               = 1'b0;
    IOOut_ACK               = 1'b0;
    IOOut_ResponseRequested = 1'b0;
    IOOut_DestReg           = 4'h0;
    IOOut_Data              = 32'h0;
    IOIn_REQ                = 1'b0;
    Busy                    = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_COLLECT_LO, S_COLLECT_HI: ByteReady = 1'b1;
      S_WRITE: begin
        IOOut_ACK  = 1'b1;
        IOOut_Data = {{(16-ADDR_W){1'b0}}, addr, word};
      end
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      S_VERIFY_REQ: begin
        IOOut_ACK               = 1'b1;
        IOOut_ResponseRequested = 1'b1;
        IOOut_DestReg           = RESP_DEST_REG;
        IOOut_Data              = {{(16-ADDR_W){1'b0}}, addr, 16'h0};
      end
      S_VERIFY_RESP: IOIn_REQ = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath: address, down-counter, byte assembly, checksums, sticky status
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      addr          <= '0;
      remaining     <= '0;
      lo_byte       <= 8'h0;
      word          <= 16'h0;
      WriteChecksum <= 16'h0;
      Done          <= 1'b0;
      ChecksumError <= 1'b0;
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      start_addr_q  <= '0;
      word_count_q  <= '0;
      read_sum      <= 16'h0;
`endif
    end else if (clk_en) begin
      if (start_ok) begin
        addr          <= StartAddr;
        remaining     <= WordCount;
        WriteChecksum <= 16'h0;
        ChecksumError <= 1'b0;
        Done          <= (WordCount == '0);
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
        start_addr_q  <= StartAddr;
        word_count_q  <= WordCount;
        read_sum      <= 16'h0;
`endif
      end
      if (state == S_COLLECT_LO && byte_xfer) lo_byte <= ByteData;
      if (state == S_COLLECT_HI && byte_xfer) word    <= {ByteData, lo_byte};
      if (state == S_WRITE && out_xfer) begin
        WriteChecksum <= WriteChecksum + word;
        addr          <= addr + 1'b1;
        remaining     <= remaining - 1'b1;
        if (last_word) begin
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
          // Readback pass restarts from the latched run parameters.
          addr      <= start_addr_q;
          remaining <= word_count_q;
`else
          Done      <= 1'b1;
`endif
        end
      end
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      if (state == S_VERIFY_RESP && in_xfer) begin
        read_sum  <= read_sum_nx;
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
        if (resp_bad) ChecksumError <= 1'b1;
        if (last_word) begin
          Done <= 1'b1;
          if (read_sum_nx != WriteChecksum) ChecksumError <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_io_flash_programmer.sv
module tb_io_flash_programmer;

  logic        clk = 1'b0;
  logic        clk_en, sync_rst, Start;
  logic [10:0] StartAddr;
  logic [11:0] WordCount;
  logic        ByteValid, ByteReady;
  logic [7:0]  ByteData;
  logic        IOOut_ACK, IOOut_REQ, IOOut_ResponseRequested;
  logic [3:0]  IOOut_DestReg;
  logic [31:0] IOOut_Data;
  logic        IOIn_ACK, IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag;
  logic [3:0]  IOIn_DestReg;
  logic [31:0] IOIn_Data;
  logic        Busy, Done, ChecksumError;
  logic [15:0] WriteChecksum;

  always #5 clk = ~clk;

  io_flash_programmer dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .Start(Start), .StartAddr(StartAddr), .WordCount(WordCount),
    .ByteValid(ByteValid), .ByteData(ByteData), .ByteReady(ByteReady),
    .IOOut_ACK(IOOut_ACK), .IOOut_REQ(IOOut_REQ),
    .IOOut_ResponseRequested(IOOut_ResponseRequested),
    .IOOut_DestReg(IOOut_DestReg), .IOOut_Data(IOOut_Data),
    .IOIn_ACK(IOIn_ACK), .IOIn_REQ(IOIn_REQ),
    .IOIn_RegResponseFlag(IOIn_RegResponseFlag),
    .IOIn_MemResponseFlag(IOIn_MemResponseFlag),
    .IOIn_DestReg(IOIn_DestReg), .IOIn_Data(IOIn_Data),
    .Busy(Busy), .Done(Done), .ChecksumError(ChecksumError),
    .WriteChecksum(WriteChecksum)
  );

  int checks = 0;
  int errors = 0;

`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // bytes: byte k of the stream is bytes[8k+:8]
  typedef struct {
    logic [10:0]       sa;
    logic [3:0]        wc;
    logic [63:0]       bytes;
    logic [3:0][10:0]  eaddr;
    logic [3:0][15:0]  edata;
    logic [15:0]       esum;
    int                stall;
    bit                tog;
    bit                poke;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {21'h0, ByteReady, IOOut_ACK, IOOut_ResponseRequested,
                          IOOut_DestReg, IOIn_REQ, Busy, Done, ChecksumError}, 32'h0);
    check({tag, "_data"}, IOOut_Data, 32'h0);
    check({tag, "_sum"}, {16'h0, WriteChecksum}, 32'h0);
  endtask

  task automatic run_vec(input int v, input bit corrupt);
    int bidx = 0, nstore = 0, nload = 0, cyc = 0;
    int stall_left = vecs[v].stall;
    int wc = int'(vecs[v].wc);
    bit pend = 0, bad_inreq = 0;
    logic [15:0] resp = 16'h0;
    string t = $sformatf("v%0d", v);

    @(negedge clk);
    clk_en = 1'b1; Start = 1'b1;
    StartAddr = vecs[v].sa; WordCount = {8'h0, vecs[v].wc};
    @(posedge clk);
    while (cyc < 400) begin
      @(negedge clk);
      // Changed run inputs after the start must not affect the run.
      Start     = vecs[v].poke && (bidx == 1);
      StartAddr = 11'h555;
      WordCount = 12'd7;
      if (cyc == 0)
        check({t, "_start_status"}, {30'h0, Done, Busy}, 32'h1);
      if (Done && !Busy) break;
      clk_en    = vecs[v].tog ? ((cyc % 2) == 0) : 1'b1;
      ByteValid = (bidx < 2 * wc) && (bidx < 8);
      ByteData  = ByteValid ? vecs[v].bytes[8*bidx +: 8] : 8'h00;
      if (IOOut_ACK && !IOOut_ResponseRequested && stall_left > 0) begin
        IOOut_REQ = 1'b0;
        stall_left--;
      end else begin
        IOOut_REQ = 1'b1;
      end
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      IOIn_ACK = pend;
      IOIn_RegResponseFlag = 1'b1;
      IOIn_DestReg = 4'h1;
      IOIn_Data = {16'hDEAD, resp};
`else
      IOIn_ACK = 1'b1;
`endif
      #1;
      if (IOIn_REQ && !VERIFY) bad_inreq = 1;
      if (IOOut_ACK && !IOOut_REQ && nstore < wc) begin
        check({t, "_stall_data"}, IOOut_Data,
              {5'b0, vecs[v].eaddr[nstore], vecs[v].edata[nstore]});
        check({t, "_stall_byteready"}, {31'h0, ByteReady}, 32'h0);
      end
      if (ByteValid && ByteReady && clk_en) bidx++;
      if (IOOut_ACK && IOOut_REQ && clk_en && !IOOut_ResponseRequested) begin
        if (nstore < wc) begin
          check($sformatf("%s_store%0d", t, nstore), IOOut_Data,
                {5'b0, vecs[v].eaddr[nstore], vecs[v].edata[nstore]});
          check($sformatf("%s_store%0d_dest", t, nstore), {28'h0, IOOut_DestReg}, 32'h0);
        end
        nstore++;
      end
`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
      if (IOIn_ACK && IOIn_REQ && clk_en) pend = 0;
      if (IOOut_ACK && IOOut_REQ && clk_en && IOOut_ResponseRequested) begin
        if (nload < wc) begin
          check($sformatf("%s_load%0d", t, nload), IOOut_Data,
                {5'b0, vecs[v].eaddr[nload], 16'h0});
          check($sformatf("%s_load%0d_dest", t, nload), {28'h0, IOOut_DestReg}, 32'h1);
          resp = vecs[v].edata[nload] + ((corrupt && nload == wc - 1) ? 16'h1 : 16'h0);
        end
        pend = 1;
        nload++;
      end
`endif
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 400) check({t, "_timeout"}, 32'(cyc), 32'd0);
    check({t, "_nstore"}, 32'(nstore), 32'(wc));
    check({t, "_wsum"}, {16'h0, WriteChecksum}, {16'h0, vecs[v].esum});
    check({t, "_end_status"}, {30'h0, Done, Busy}, 32'h2);
    check({t, "_chkerr"}, {31'h0, ChecksumError}, {31'h0, VERIFY && corrupt});
    if (VERIFY) check({t, "_nload"}, 32'(nload), 32'(wc));
    else        check({t, "_inreq"}, {31'h0, bad_inreq}, 32'h0);
    if (!VERIFY && !vecs[v].tog && vecs[v].stall == 0)
      check({t, "_latency"}, 32'(cyc), 32'(3 * wc));
    Start = 1'b0; ByteValid = 1'b0; IOOut_REQ = 1'b0; IOIn_ACK = 1'b0; clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({t, "_idle_hold"}, {30'h0, Done, Busy}, 32'h2);
  endtask

  task automatic wc_zero(input string t);
    int acks = 0;
    @(negedge clk);
    clk_en = 1'b1; Start = 1'b1; StartAddr = 11'h123; WordCount = 12'd0;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    check({t, "_status"}, {30'h0, Done, Busy}, 32'h2);
    check({t, "_sum"}, {16'h0, WriteChecksum}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (IOOut_ACK) acks++;
      @(negedge clk);
    end
    check({t, "_acks"}, 32'(acks), 32'd0);
  endtask

  initial begin
    vecs[0] = '{11'h010, 4'd2, 64'h0000_0000_5678_1234,
                {11'h0, 11'h0, 11'h011, 11'h010},
                {16'h0, 16'h0, 16'h5678, 16'h1234}, 16'h68AC, 0, 1'b0, 1'b0};
    vecs[1] = '{11'h7FF, 4'd2, 64'h0000_0000_EF01_ABCD,
                {11'h0, 11'h0, 11'h000, 11'h7FF},
                {16'h0, 16'h0, 16'hEF01, 16'hABCD}, 16'h9ACE, 0, 1'b0, 1'b0};
    vecs[2] = vecs[0];
    vecs[2].tog = 1'b1;
    vecs[3] = '{11'h100, 4'd3, 64'h0000_8002_0001_FFFF,
                {11'h0, 11'h102, 11'h101, 11'h100},
                {16'h0, 16'h8002, 16'h0001, 16'hFFFF}, 16'h8002, 5, 1'b0, 1'b1};
    vecs[4] = '{11'h7FE, 4'd4, 64'h8877_6655_4433_2211,
                {11'h001, 11'h000, 11'h7FF, 11'h7FE},
                {16'h8877, 16'h6655, 16'h4433, 16'h2211}, 16'h5510, 0, 1'b0, 1'b0};

    clk_en = 1'b0; sync_rst = 1'b1; Start = 1'b0;
    StartAddr = '0; WordCount = '0; ByteValid = 1'b0; ByteData = '0;
    IOOut_REQ = 1'b0; IOIn_ACK = 1'b0; IOIn_RegResponseFlag = 1'b0;
    IOIn_MemResponseFlag = 1'b0; IOIn_DestReg = '0; IOIn_Data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // clk_en low: Start must not be taken
    sync_rst = 1'b0; Start = 1'b1; StartAddr = 11'h010; WordCount = 12'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("clken_low_busy", {31'h0, Busy}, 32'h0);
    Start = 1'b0; clk_en = 1'b1;
    @(posedge clk);

    wc_zero("wc0_fresh");

    for (int v = 0; v < 5; v++) run_vec(v, 1'b0);

    wc_zero("wc0_after_run");

`ifdef IO_FLASH_PROGRAMMER_VERIFY_EN
    run_vec(0, 1'b1);
`endif

    // Reset while a store is pending
    @(negedge clk);
    Start = 1'b1; StartAddr = 11'h020; WordCount = 12'd1; IOOut_REQ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; ByteValid = 1'b1; ByteData = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    ByteData = 8'h55;
    @(posedge clk);
    @(negedge clk);
    ByteValid = 1'b0;
    check("rstmid_ack", {31'h0, IOOut_ACK}, 32'h1);
    check("rstmid_data", IOOut_Data, {5'b0, 11'h020, 16'h55AA});
    sync_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rstmid");
    sync_rst = 1'b0; IOOut_REQ = 1'b1; ByteValid = 1'b1;
    begin
      int acks = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (IOOut_ACK) acks++;
      end
      check("rstmid_no_ack", 32'(acks), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
